// File: rtl/relay_arb_pkg.sv
// ---------------------------------------------------------------------------
// relay_arb_pkg
// Shared definitions for the relay power arbiter:
//   - ch_state_e  : per-channel relay state
//   - DEF_*       : default timing constants, in 16 ms ticks
//   - hold_cnt_w(): width of a hold counter able to hold max(MIN_ON, MIN_OFF)
// ---------------------------------------------------------------------------
package relay_arb_pkg;

  typedef enum logic [1:0] {
    OFF_READY = 2'd0,  // off, eligible for a grant
    ON_HOLD   = 2'd1,  // on, minimum on-time still running
    ON_FREE   = 2'd2,  // on, may drop as soon as the request goes away
    OFF_LOCK  = 2'd3   // off, minimum off-time still running
  } ch_state_e;

  localparam int DEF_MIN_ON  = 8;
  localparam int DEF_MIN_OFF = 8;
  localparam int DEF_STAGGER = 2;

  // Counter width for the larger of the two hold times (at least one bit).
  function automatic int hold_cnt_w(input int min_on, input int min_off);
    int m;
    m = (min_on > min_off) ? min_on : min_off;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/relay_power_arbiter_if.sv
// ---------------------------------------------------------------------------
// relay_power_arbiter_if
// Bundles the arbiter's functional signals.
//   enable   : global enable, low forces every relay off
//   req      : per-channel relay requests from the sensor FSMs
//   relay    : registered relay drive
//   waiting  : registered req & ~relay
//   on_count : registered number of energised relays
// Modports: master = request side (drives enable/req), slave = arbiter.
// ---------------------------------------------------------------------------
interface relay_power_arbiter_if #(
  parameter int N_CH = 3
);
  localparam int CNT_W = $clog2(N_CH + 1);

  logic             enable;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  relay;
  logic [N_CH-1:0]  waiting;
  logic [CNT_W-1:0] on_count;

  modport master (
    output enable, req,
    input  relay, waiting, on_count
  );

  modport slave (
    input  enable, req,
    output relay, waiting, on_count
  );
endinterface

// File: rtl/relay_channel_timer.sv
// ---------------------------------------------------------------------------
// relay_channel_timer
// One relay channel: state machine plus hold counter that enforces the
// minimum on-time and minimum off-time.
// Ports:
//   clk_16ms    : 16 ms tick clock
//   rst         : asynchronous active-low reset
//   i_grant     : turn-on grant from the arbiter (only when o_ready)
//   i_req       : relay request for this channel
//   i_force_off : global safety override, drops the relay regardless of hold
//   o_relay     : registered relay drive
//   o_relay_nxt : value o_relay takes at the coming edge (for the arbiter's
//                 registered popcount / waiting flags)
//   o_ready     : channel may be granted on the coming edge
// A hold of N ticks is satisfied at the edge that completes the Nth tick;
// on that edge the channel already acts on req (drops or becomes grantable),
// so a relay is on for exactly MIN_ON ticks and off for exactly MIN_OFF ticks
// at minimum.
// ---------------------------------------------------------------------------
module relay_channel_timer
  import relay_arb_pkg::*;
#(
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF,
  parameter int CNT_W   = hold_cnt_w(MIN_ON, MIN_OFF)
) (
  input  logic clk_16ms,
  input  logic rst,
  input  logic i_grant,
  input  logic i_req,
  input  logic i_force_off,
  output logic o_relay,
  output logic o_relay_nxt,
  output logic o_ready
);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_relay;

  logic w_expire;
  logic w_drop;

  // Hold is satisfied once this edge completes (also covers a zero hold).
  assign w_expire = (r_cnt <= ONE);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // latch is inferred on paths the case does not cover.
  always_comb begin
    w_drop = 1'b0;
    case (r_state)
      ON_HOLD: w_drop = i_force_off || (w_expire && !i_req);
      ON_FREE: w_drop = i_force_off || !i_req;
      default: w_drop = 1'b0;
    endcase
  end

  assign o_ready     = (r_state == OFF_READY) || ((r_state == OFF_LOCK) && w_expire);
  assign o_relay     = r_relay;
  assign o_relay_nxt = (r_relay && !w_drop) || i_grant;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_16ms or negedge rst) begin
    if (!rst) begin
      r_state <= OFF_READY;
      r_cnt   <= '0;
      r_relay <= 1'b0;
    end else begin
      case (r_state)
        OFF_READY: begin
          if (i_grant) begin
            r_state <= ON_HOLD;
            r_cnt   <= ON_LOAD;
            r_relay <= 1'b1;
          end
        end
        ON_HOLD: begin
          if (w_drop) begin
            r_state <= OFF_LOCK;
            r_cnt   <= OFF_LOAD;
            r_relay <= 1'b0;
          end else if (w_expire) begin
            r_state <= ON_FREE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ON_FREE: begin
          if (w_drop) begin
            r_state <= OFF_LOCK;
            r_cnt   <= OFF_LOAD;
            r_relay <= 1'b0;
          end
        end
        OFF_LOCK: begin
          if (w_expire) begin
            if (i_grant) begin
              r_state <= ON_HOLD;
              r_cnt   <= ON_LOAD;
              r_relay <= 1'b1;
            end else begin
              r_state <= OFF_READY;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= OFF_READY;
          r_cnt   <= '0;
          r_relay <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/relay_power_arbiter.sv
// ---------------------------------------------------------------------------
// relay_power_arbiter
// Shares the relay-coil power budget among per-sensor relay requests:
// at most MAX_ON relays energised, turn-on edges at least STAGGER ticks
// apart, and per-channel minimum on/off hold times (relay_channel_timer).
// Ports:
//   clk_16ms : 16 ms tick clock, all state updates on the rising edge
//   rst      : asynchronous active-low reset
//   bus      : relay_power_arbiter_if.slave (enable, req, relay, waiting,
//              on_count)
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin; all other behaviour is identical.
// ---------------------------------------------------------------------------
module relay_power_arbiter
  import relay_arb_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int MAX_ON  = 2,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF,
  parameter int STAGGER = DEF_STAGGER
) (
  input logic                  clk_16ms,
  input logic                  rst,
  relay_power_arbiter_if.slave bus
);

  localparam int CNT_W  = $clog2(N_CH + 1);
  localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int HOLD_W = hold_cnt_w(MIN_ON, MIN_OFF);

  localparam logic [CNT_W-1:0] MAX_ON_C = CNT_W'(MAX_ON);
  // Loaded on a grant; the next grant waits until it has counted down to 0.
  localparam logic [STG_W-1:0] STG_LOAD = STG_W'(STAGGER - 1);

  logic [N_CH-1:0]  w_relay;
  logic [N_CH-1:0]  w_relay_nxt;
  logic [N_CH-1:0]  w_ready;
  logic [N_CH-1:0]  w_cand;
  logic [N_CH-1:0]  w_grant;
  logic             w_force_off;
  logic             w_can_grant;
  logic             w_found;
  logic [PTR_W-1:0] w_sel;

  logic [STG_W-1:0] r_stagger;
  logic [CNT_W-1:0] r_on_count;
  logic [N_CH-1:0]  r_waiting;

  assign w_force_off = ~bus.enable;
  assign w_cand      = bus.req & w_ready;
  // Budget uses the registered count: a slot freed this edge is reusable
  // only from the next edge, so the cap holds even transiently.
  assign w_can_grant = bus.enable && (r_stagger == '0) && (r_on_count < MAX_ON_C);

`ifdef ARB_FIXED_PRIO_EN
  function automatic logic [PTR_W:0] pick_fixed(input logic [N_CH-1:0] cand);
    logic             found;
    logic [PTR_W-1:0] sel;
    found = 1'b0;
    sel   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found = 1'b1;
        sel   = PTR_W'(i);
      end
    end
    return {found, sel};
  endfunction

  assign {w_found, w_sel} = pick_fixed(w_cand);
`else
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_CH - 1);

  // Next channel to search from; advances only when a grant is issued.
  logic [PTR_W-1:0] r_ptr;

  function automatic logic [PTR_W:0] pick_rr(input logic [N_CH-1:0]  cand,
                                             input logic [PTR_W-1:0] start);
    logic             found;
    logic [PTR_W-1:0] sel;
    int               idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(start) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && cand[PTR_W'(idx)]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
    return {found, sel};
  endfunction

  assign {w_found, w_sel} = pick_rr(w_cand, r_ptr);

  always_ff @(posedge clk_16ms or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_grant != '0) begin
      r_ptr <= (w_sel == LAST_IDX) ? '0 : w_sel + 1'b1;
    end
  end
`endif

  always_comb begin
    w_grant = '0;
    if (w_can_grant && w_found) w_grant[w_sel] = 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    relay_channel_timer #(
      .MIN_ON (MIN_ON),
      .MIN_OFF(MIN_OFF),
      .CNT_W  (HOLD_W)
    ) u_timer (
      .clk_16ms   (clk_16ms),
      .rst        (rst),
      .i_grant    (w_grant[g]),
      .i_req      (bus.req[g]),
      .i_force_off(w_force_off),
      .o_relay    (w_relay[g]),
      .o_relay_nxt(w_relay_nxt[g]),
      .o_ready    (w_ready[g])
    );
  end

  always_ff @(posedge clk_16ms or negedge rst) begin
    if (!rst) begin
      r_stagger  <= '0;
      r_on_count <= '0;
      r_waiting  <= '0;
    end else begin
      if (w_force_off)             r_stagger <= '0;
      else if (w_grant != '0)      r_stagger <= STG_LOAD;
      else if (r_stagger != '0)    r_stagger <= r_stagger - 1'b1;
      // Both flags track the relay value this edge produces.
      r_on_count <= CNT_W'($countones(w_relay_nxt));
      r_waiting  <= bus.req & ~w_relay_nxt;
    end
  end

  assign bus.relay    = w_relay;
  assign bus.waiting  = r_waiting;
  assign bus.on_count = r_on_count;

endmodule

// File: tb/tb_relay_power_arbiter.sv
// ---------------------------------------------------------------------------
// tb_relay_power_arbiter
// Directed stimulus with hand-derived relay values per edge. Each edge pushes
// its expected {relay, waiting, on_count} into a queue; a monitor on the
// falling edge pops and compares. waiting and on_count expectations follow
// from the expected relay value and the req sampled at that edge.
// Default build: reset, budget/stagger, MIN_ON + slot reuse, MIN_OFF, safety.
// ARB_FIXED_PRIO_EN build: MAX_ON=1 fixed-priority scenario.
// ---------------------------------------------------------------------------
module tb_relay_power_arbiter;

  localparam int N_CH = 3;
`ifdef ARB_FIXED_PRIO_EN
  localparam int TB_MAX_ON = 1;
`else
  localparam int TB_MAX_ON = 2;
`endif

  typedef struct packed {
    logic [N_CH-1:0] relay;
    logic [N_CH-1:0] waiting;
    logic [1:0]      on_count;
  } exp_t;

  logic clk_16ms = 1'b0;
  logic rst      = 1'b1;

  always #5 clk_16ms = ~clk_16ms;

  relay_power_arbiter_if #(.N_CH(N_CH)) bus ();

  relay_power_arbiter #(
    .N_CH   (N_CH),
    .MAX_ON (TB_MAX_ON),
    .MIN_ON (8),
    .MIN_OFF(8),
    .STAGGER(2)
  ) dut (
    .clk_16ms(clk_16ms),
    .rst     (rst),
    .bus     (bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    edge_no  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait for the next edge and record what the DUT must show after it.
  task automatic tick(input string tag, input logic [N_CH-1:0] exp_relay);
    exp_t e;
    @(posedge clk_16ms);
    e.relay    = exp_relay;
    e.waiting  = rst ? (bus.req & ~exp_relay) : '0;
    e.on_count = 2'($countones(exp_relay));
    exp_q.push_back(e);
    name_q.push_back($sformatf("%s_e%0d", tag, edge_no));
    edge_no++;
    #1;
  endtask

  task automatic run(input string tag, input int n, input logic [N_CH-1:0] exp_relay);
    for (int k = 0; k < n; k++) tick(tag, exp_relay);
  endtask

  // Reset with req=111 held; ends just after an edge, so the next edge is edge 0.
  task automatic do_reset(input string tag);
    @(negedge clk_16ms);
    #1;
    bus.enable = 1'b1;
    bus.req    = '1;
    rst        = 1'b0;
    edge_no    = 0;
    run({tag, "_rst"}, 3, 3'b000);
    bus.req = '0;
    rst     = 1'b1;
    edge_no = 0;
  endtask

  // Monitor: compare whenever an expectation is pending.
  exp_t  mon_e;
  string mon_n;
  always @(negedge clk_16ms) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      check({mon_n, "_relay"},    32'(bus.relay),    32'(mon_e.relay));
      check({mon_n, "_waiting"},  32'(bus.waiting),  32'(mon_e.waiting));
      check({mon_n, "_on_count"}, 32'(bus.on_count), 32'(mon_e.on_count));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable = 1'b1;
    bus.req    = '1;
    #1;

`ifndef ARB_FIXED_PRIO_EN
    // Reset, then budget + stagger with all three requesting.
    do_reset("t1");
    run("t2", 1, 3'b000);          // e0: req applied after this edge
    bus.req = 3'b111;
    run("t2", 2, 3'b001);          // e1-e2: ch0 first, stagger blocks e2
    run("t2", 2, 3'b011);          // e3-e4: ch1, ch2 blocked by budget
    // MIN_ON holds ch0 although req[0] drops; freed slot reused one edge later.
    bus.req = 3'b110;
    run("t3", 4, 3'b011);          // e5-e8
    run("t3", 1, 3'b010);          // e9: ch0 off after 8 ticks on
    run("t3", 1, 3'b110);          // e10: ch2 granted
    // MIN_OFF keeps ch0 locked until e17; ch1 drops once its hold ends.
    bus.req = 3'b101;
    run("t4", 6, 3'b100);          // e11: ch1 off; e12-e16 ch0 still locked
    run("t4", 2, 3'b101);          // e17: ch0 back on
    // Safety override while relay=011, then lockout and staggered restart.
    do_reset("t5");
    run("t5", 1, 3'b000);          // e0
    bus.req = 3'b011;
    run("t5", 2, 3'b001);          // e1-e2
    run("t5", 2, 3'b011);          // e3-e4: both inside MIN_ON
    bus.enable = 1'b0;
    run("t5", 2, 3'b000);          // e5: forced off; e6 still disabled
    bus.enable = 1'b1;
    run("t5", 6, 3'b000);          // e7-e12: MIN_OFF lockout
    run("t5", 2, 3'b001);          // e13: 8 ticks after forced off
    run("t5", 2, 3'b011);          // e15: STAGGER later
`else
    // MAX_ON=1, fixed priority: ch0 wins every contention with ch2.
    do_reset("t6");
    run("t6", 1, 3'b000);          // e0
    bus.req = 3'b101;
    run("t6", 1, 3'b001);          // e1: contention, ch0 wins
    bus.req = 3'b000;
    run("t6", 7, 3'b001);          // e2-e8: MIN_ON
    run("t6", 1, 3'b000);          // e9: ch0 off, locked to e17
    run("t6", 8, 3'b000);          // e10-e17: nobody requesting
    bus.req = 3'b101;
    run("t6", 1, 3'b001);          // e18: contention again, ch0 wins
    bus.req = 3'b100;
    run("t6", 7, 3'b001);          // e19-e25
    run("t6", 1, 3'b000);          // e26: ch0 off, budget still full
    run("t6", 2, 3'b100);          // e27-e28: ch2 while ch0 locked out
`endif

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk_16ms);
      #1;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/relay_power_arbiter.md
Name: relay_power_arbiter

Overview:
- Shares a limited relay-coil power budget among the per-sensor relay requests produced by the individual sensor FSMs.
- Decides which relays may actually energize, and when.
- Enforces: a maximum number of simultaneously energized relays, staggered turn-on to limit inrush, and minimum on/off hold times against chatter.
- Sits between the per-sensor FSM relay outputs and the physical relay drivers, clocked by the 16 ms tick clock.

Parameters:
- N_CH, 3: number of relay channels.
- MAX_ON, 2: maximum relays energized at once (1..N_CH).
- MIN_ON, 8: minimum ticks a relay stays on once granted.
- MIN_OFF, 8: minimum ticks a relay stays off after de-energizing.
- STAGGER, 2: minimum ticks between two consecutive turn-on edges (>=1).

Ports:
- clk_16ms  input  1  16 ms tick clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  global enable; low forces all relays off.
- req  input  N_CH  relay requests, one per sensor FSM.
- relay  output  N_CH  registered relay drive.
- waiting  output  N_CH  registered; req & ~relay.
- on_count  output  $clog2(N_CH+1)  registered popcount of relay.

Behaviour:
- Reset (rst=0, async):
  - relay=0, waiting=0, on_count=0.
  - All MIN_OFF lockout counters cleared, so channels are immediately eligible.
  - MIN_ON counters = 0, stagger counter = 0, round-robin pointer = 0.
- Per-channel states: OFF_READY, ON_HOLD, ON_FREE, OFF_LOCK.
  - ON_HOLD: relay on, MIN_ON counter running; req ignored.
  - ON_FREE: relay on, MIN_ON elapsed; req=0 -> OFF_LOCK on next edge.
  - OFF_LOCK: relay off, MIN_OFF counter running; req ignored.
  - Transitions after exactly MIN_ON / MIN_OFF ticks in state: ON_HOLD->ON_FREE, OFF_LOCK->OFF_READY.
- Turn-on grant, at most one per edge, issued when all of the following hold:
  - enable=1;
  - stagger window elapsed;
  - registered on_count < MAX_ON;
  - at least one channel is in OFF_READY with req=1.
- Grant choice and timing:
  - Round-robin: search starts at the channel after the last granted one; the pointer updates only on a grant.
  - The granted channel goes OFF_READY->ON_HOLD and its relay rises on the same edge, so req-to-relay latency is 1 tick when unblocked.
  - Consecutive turn-on edges are at least STAGGER ticks apart.
- Turn-offs are never limited by stagger or budget; any number may occur on one edge.
- Same-edge turn-off and turn-on: the budget check uses the registered on_count. A slot freed at edge k is usable at edge k+1 at the earliest, so the MAX_ON cap is never exceeded, even transiently.
- enable=0 (safety override, sampled each edge):
  - All ON channels go to OFF_LOCK on the next edge, regardless of MIN_ON.
  - No grants issued; stagger counter cleared.
  - When enable returns, MIN_OFF still applies and grants resume normally.
- Counters saturate at zero; parameter values of 0 for MIN_ON/MIN_OFF mean no hold.
- on_count and waiting reflect the post-edge relay value.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
  - Defined: fixed priority replaces round-robin; lowest index wins; pointer logic removed.
  - Undefined: round-robin as above.
  - All other rules are identical in both modes.

Decomposition:
- Shared package relay_arb_pkg holds:
  - the channel-state enum (OFF_READY, ON_HOLD, ON_FREE, OFF_LOCK);
  - default timing constants (MIN_ON, MIN_OFF, STAGGER);
  - the hold-counter width derived from max(MIN_ON, MIN_OFF).
- Sub-module relay_channel_timer, instantiated N_CH times: per-channel state and hold counter; inputs grant, req, force_off; outputs relay and ready.
- Top level holds the budget check, stagger counter and grant selection.

Test Plan:
All tests use defaults; edge 0 = first edge after reset release.
1. Reset: rst=0 with req=111 -> relay=000, on_count=0, waiting=000, held throughout reset.
2. Budget and stagger: req=111 from edge 0.
   - relay=001 at edge1, relay=011 at edge3, relay[2] stays 0.
   - waiting=100, on_count=2.
3. MIN_ON and slot reuse: continue from test 2; drop req[0] at edge4.
   - relay[0] stays 1 through edge8 and falls at edge9.
   - relay[2] rises at edge10 (freed slot usable one tick later; round-robin picks ch2).
4. MIN_OFF: continue from test 3; raise req[0] again at edge10 and drop req[1] at edge10.
   - relay[1] falls when its MIN_ON allows.
   - relay[0] stays 0 until edge17 (lockout), then rises once a slot and stagger allow.
5. Safety: enable=0 while relay=011 -> relay=000 on the next edge, ignoring MIN_ON.
   - Re-enable with req=111: no relay rises before 8 ticks after the forced off.
   - Restart grants are STAGGER-spaced.
6. ARB_FIXED_PRIO_EN defined, MAX_ON=1: ch0 and ch2 both ready with req=1 -> ch0 granted on every contention, including after ch0 cycles off and back on; ch2 granted only while ch0 is idle or locked out.
